// File: rtl/bus_ctrl.sv
// bus_ctrl: single-master, N-slave memory bus controller.
// Decodes the region from addr[31:28] and forwards one transaction at a time
// to the selected slave over a req/ack handshake. Unmapped accesses and
// slaves that never acknowledge complete with an error. A saturating counter
// tracks error completions. All outputs are registered.
module bus_ctrl #(
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERRCNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_req,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  input  logic [3:0]               m_we,
  output logic                     m_ack,
  output logic [31:0]              m_rdata,
  output logic                     m_err,
  output logic [NUM_SLAVES-1:0]    s_req,
  output logic [NUM_SLAVES*32-1:0] s_addr,
  output logic [NUM_SLAVES*32-1:0] s_wdata,
  output logic [NUM_SLAVES*4-1:0]  s_we,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ack,
  output logic [ERRCNT_W-1:0]      err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              region;
  logic [NUM_SLAVES-1:0]   dec;
  logic                    ack_hit;
  logic [31:0]             rdata_hit;

  assign region = m_addr[31:28];

  // Region decode and selected-slave ack/read-data mux. The s_req register is
  // one-hot on the selected slave while BUSY, so masking s_ack with it honours
  // only the selected port and ignores acks in every other state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    dec       = '0;
    ack_hit   = |(s_ack & s_req);
    rdata_hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec[i] = (region == 4'(i + 1));
      if (s_req[i]) begin
        rdata_hit = rdata_hit | s_rdata[i*32 +: 32];
      end
    end
  end

  // Transaction FSM: accept in IDLE, hold the slave request in BUSY until ack
  // or timeout, present the one-cycle completion in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      // NOTE: the payload registers are reset too, because they drive the
      // slave ports directly and must read 0 whenever no slave is selected.
      state   <= IDLE;
      cnt     <= '0;
      m_ack   <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;
      s_req   <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_we    <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req) begin
            if (|dec) begin
              // Mapped: the slave port registers double as the payload latch.
              state <= BUSY;
              cnt   <= '0;
              s_req <= dec;
              for (int i = 0; i < NUM_SLAVES; i++) begin
                s_addr[i*32 +: 32] <= dec[i] ? m_addr  : 32'd0;
                s_wdata[i*32 +: 32] <= dec[i] ? m_wdata : 32'd0;
                s_we[i*4 +: 4]      <= dec[i] ? m_we    : 4'd0;
              end
            end else begin
              // Unmapped: complete immediately with an error, no slave sees it.
              state   <= RESP;
              m_ack   <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= '0;
            end
          end
        end

        BUSY: begin
          if (ack_hit || cnt == CNT_LAST) begin
            state   <= RESP;
            m_ack   <= 1'b1;
            // Writes capture read data too; the master ignores it.
            m_err   <= !ack_hit;
            m_rdata <= ack_hit ? rdata_hit : 32'd0;
            s_req   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_we    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          state   <= IDLE;
          m_ack   <= 1'b0;
          m_err   <= 1'b0;
          m_rdata <= '0;
          if (m_err && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed testbench for bus_ctrl with NUM_SLAVES=2, TIMEOUT_CYCLES=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_we;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [1:0]  s_req;
  logic [63:0] s_addr;
  logic [63:0] s_wdata;
  logic [7:0]  s_we;
  logic [63:0] s_rdata;
  logic [1:0]  s_ack;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  bus_ctrl #(
    .NUM_SLAVES(2),
    .TIMEOUT_CYCLES(16),
    .ERRCNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_req(m_req),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_we(m_we),
    .m_ack(m_ack),
    .m_rdata(m_rdata),
    .m_err(m_err),
    .s_req(s_req),
    .s_addr(s_addr),
    .s_wdata(s_wdata),
    .s_we(s_we),
    .s_rdata(s_rdata),
    .s_ack(s_ack),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int high_cnt;
    int ack_cnt;
    int ack_cyc;
    logic ack_err;
    logic [31:0] ack_rdata;

    // Reset with random inputs: every output must read 0.
    rst_n   = 1'b0;
    m_req   = 1'($urandom);
    m_addr  = $urandom;
    m_wdata = $urandom;
    m_we    = 4'($urandom);
    s_rdata = {$urandom, $urandom};
    s_ack   = 2'($urandom);
    cyc(); cyc();
    check("rst_m_ack",   64'(m_ack),   64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_m_err",   64'(m_err),   64'd0);
    check("rst_s_req",   64'(s_req),   64'd0);
    check("rst_s_addr",  s_addr,       64'd0);
    check("rst_s_wdata", s_wdata,      64'd0);
    check("rst_s_we",    64'(s_we),    64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Release, request slave 1 with no ack, wrong-port ack, then abort by reset.
    m_req = 1'b0; s_ack = 2'b00; s_rdata = {32'hAAAA_5555, 32'h1234_5678};
    rst_n = 1'b1;
    cyc();
    m_req = 1'b1; m_addr = 32'h2000_0000; m_wdata = 32'h0; m_we = 4'h0;
    cyc();                                   // cycle 1: BUSY
    check("abort_s_req", 64'(s_req), 64'b10);
    check("abort_noack1", 64'(m_ack), 64'd0);
    s_ack = 2'b01;                           // ack on the non-selected port
    cyc();
    check("wrong_port_noack", 64'(m_ack), 64'd0);
    check("wrong_port_s_req", 64'(s_req), 64'b10);
    s_ack = 2'b00;
    cyc();
    check("abort_noack3", 64'(m_ack), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_s_req_drop", 64'(s_req), 64'd0);
    m_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("abort_no_m_ack", 64'(m_ack), 64'd0);

    // Write to slave 1, ack in the first BUSY cycle.
    m_req = 1'b1; m_addr = 32'h2000_0010; m_wdata = 32'hDEAD_BEEF; m_we = 4'hF;
    cyc();                                   // cycle 1
    m_addr = 32'h1111_1111; m_wdata = 32'h0; m_we = 4'h0;  // must not affect payload
    check("wr_s_req",   64'(s_req), 64'b10);
    check("wr_s_addr",  s_addr,     {32'h2000_0010, 32'h0});
    check("wr_s_wdata", s_wdata,    {32'hDEAD_BEEF, 32'h0});
    check("wr_s_we",    64'(s_we),  64'hF0);
    check("wr_m_ack_c1", 64'(m_ack), 64'd0);
    s_ack = 2'b10;
    cyc();                                   // cycle 2
    check("wr_m_ack", 64'(m_ack), 64'd1);
    check("wr_m_err", 64'(m_err), 64'd0);
    check("wr_s_req_off", 64'(s_req), 64'd0);
    m_req = 1'b0; s_ack = 2'b00;
    cyc();
    check("wr_m_ack_done", 64'(m_ack), 64'd0);

    // Read from slave 0, ack on the 3rd BUSY cycle: m_ack in cycle 4.
    m_req = 1'b1; m_addr = 32'h1000_0004; m_wdata = 32'h0; m_we = 4'h0;
    cyc();                                   // cycle 1
    check("rd_s_req",  64'(s_req), 64'b01);
    check("rd_s_addr", s_addr,     {32'h0, 32'h1000_0004});
    check("rd_wait1",  64'(m_ack), 64'd0);
    cyc();                                   // cycle 2
    check("rd_wait2",  64'(m_ack), 64'd0);
    cyc();                                   // cycle 3
    check("rd_wait3",  64'(m_ack), 64'd0);
    s_ack = 2'b01;
    cyc();                                   // cycle 4
    check("rd_m_ack",   64'(m_ack),   64'd1);
    check("rd_m_rdata", 64'(m_rdata), 64'h1234_5678);
    check("rd_m_err",   64'(m_err),   64'd0);
    m_req = 1'b0; s_ack = 2'b00;
    cyc();
    check("rd_rdata_clear", 64'(m_rdata), 64'd0);
    check("rd_err_cnt", 64'(err_cnt), 64'd0);

    // Unmapped 0x0000_0000 then 0x3000_0000.
    m_req = 1'b1; m_addr = 32'h0000_0000;
    cyc();
    check("um0_s_req", 64'(s_req), 64'd0);
    check("um0_m_ack", 64'(m_ack), 64'd1);
    check("um0_m_err", 64'(m_err), 64'd1);
    check("um0_rdata", 64'(m_rdata), 64'd0);
    m_req = 1'b0;
    cyc();
    check("um0_err_cnt", 64'(err_cnt), 64'd1);
    m_req = 1'b1; m_addr = 32'h3000_0000;
    cyc();
    check("um3_s_req", 64'(s_req), 64'd0);
    check("um3_m_ack", 64'(m_ack), 64'd1);
    check("um3_m_err", 64'(m_err), 64'd1);
    m_req = 1'b0;
    cyc();
    check("um3_err_cnt", 64'(err_cnt), 64'd2);

    // Timeout on slave 1: s_req high 16 cycles, m_ack in cycle 17, late ack at 19.
    m_req = 1'b1; m_addr = 32'h2000_0008; m_we = 4'h0;
    high_cnt = 0; ack_cnt = 0; ack_cyc = 0; ack_err = 1'b0; ack_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 22; c++) begin
      cyc();
      if (s_req == 2'b10) high_cnt++;
      if (m_ack) begin
        ack_cnt++;
        ack_cyc   = c;
        ack_err   = m_err;
        ack_rdata = m_rdata;
        m_req     = 1'b0;
      end
      s_ack = (c == 19) ? 2'b10 : 2'b00;
    end
    check("to_s_req_cycles", 64'(high_cnt),  64'd16);
    check("to_ack_cycle",    64'(ack_cyc),   64'd17);
    check("to_ack_count",    64'(ack_cnt),   64'd1);
    check("to_m_err",        64'(ack_err),   64'd1);
    check("to_m_rdata",      64'(ack_rdata), 64'd0);
    check("to_err_cnt",      64'(err_cnt),   64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
